// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes a sampled Johnson code to index/one-hot,
// checks successor legality, tracks lock and counts sequence/code errors.
module johnson_decoder #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 4,
    parameter  int ERRW     = 8,
    localparam int N        = 2 * WIDTH,
    localparam int IW       = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WIDTH-1:0] code_in,
    input  logic            code_valid,
    output logic [IW-1:0]   index,
    output logic [N-1:0]    onehot,
    output logic            code_ok,
    output logic            seq_err,
    output logic            locked,
    output logic [ERRW-1:0] err_count
);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t          state, state_n;
    logic [7:0]      good, good_n;
    logic [IW-1:0]   ref_idx, ref_n;
    logic [IW-1:0]   index_n;
    logic [N-1:0]    onehot_n;
    logic            code_ok_n, err_inc;
    logic [ERRW-1:0] err_count_n;

    logic [IW:0]     trans, k, new_idx, step;
    logic            legal;

    // A legal Johnson code has at most one 0/1 boundary between neighbours.
    always_comb begin
        trans = '0;
        k     = '0;
        for (int i = 0; i < WIDTH - 1; i++)
            trans = trans + (IW+1)'(code_in[i] ^ code_in[i+1]);
        for (int i = 0; i < WIDTH; i++)
            k = k + (IW+1)'(code_in[i]);
        legal = (trans <= (IW+1)'(1));
        if (code_in[WIDTH-1])
            new_idx = k;
        else if (k != '0)
            new_idx = (IW+1)'(N) - k;
        else
            new_idx = '0;
        // Forward distance from the reference position, modulo N.
        if (new_idx >= {1'b0, ref_idx})
            step = new_idx - {1'b0, ref_idx};
        else
            step = new_idx + (IW+1)'(N) - {1'b0, ref_idx};
    end

    always_comb begin
        state_n   = state;
        good_n    = good;
        ref_n     = ref_idx;
        index_n   = index;
        onehot_n  = onehot;
        code_ok_n = code_ok;
        err_inc   = 1'b0;
        if (code_valid) begin
            if (!legal) begin
                code_ok_n = 1'b0;
                onehot_n  = '0;
                err_inc   = 1'b1;
                state_n   = UNLOCKED;
                good_n    = '0;
            end else begin
                code_ok_n = 1'b1;
                index_n   = new_idx[IW-1:0];
                onehot_n  = '0;
                onehot_n[new_idx[IW-1:0]] = 1'b1;
                case (state)
                    UNLOCKED: begin
                        ref_n   = new_idx[IW-1:0];
                        good_n  = '0;
                        state_n = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (step == (IW+1)'(1)) begin
                            ref_n  = new_idx[IW-1:0];
                            good_n = good + 8'd1;
                            if (good + 8'd1 >= 8'(LOCK_CNT))
                                state_n = LOCKED;
                        end else if (step != '0) begin
                            ref_n  = new_idx[IW-1:0];
                            good_n = '0;
                        end
                    end
                    LOCKED: begin
                        if (step == (IW+1)'(1)) begin
                            ref_n = new_idx[IW-1:0];
                        end else if (step != '0) begin
                            err_inc = 1'b1;
                            ref_n   = new_idx[IW-1:0];
                            good_n  = '0;
                            state_n = ACQUIRE;
                        end
                    end
                    default: state_n = UNLOCKED;
                endcase
            end
        end
        err_count_n = (err_inc && err_count != '1) ? err_count + 1'b1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNLOCKED;
            good      <= '0;
            ref_idx   <= '0;
            index     <= '0;
            onehot    <= '0;
            code_ok   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            good      <= good_n;
            ref_idx   <= ref_n;
            index     <= index_n;
            onehot    <= onehot_n;
            code_ok   <= code_ok_n;
            seq_err   <= err_inc;
            locked    <= (state_n == LOCKED);
            err_count <= err_count_n;
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed-vector scoreboard bench for johnson_decoder (default and ERRW=2 instances).
module tb_johnson_decoder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, v0 = 1'b0, rst1 = 1'b1, v1 = 1'b0;
    logic [3:0] c0 = '0, c1 = '0;
    logic [2:0] idx0, idx1;
    logic [7:0] oh0, oh1, ec0;
    logic [1:0] ec1;
    logic       ok0, se0, lk0, ok1, se1, lk1;

    johnson_decoder #(.WIDTH(4), .LOCK_CNT(4), .ERRW(8)) dut0 (
        .clk(clk), .reset(rst0), .code_in(c0), .code_valid(v0),
        .index(idx0), .onehot(oh0), .code_ok(ok0), .seq_err(se0),
        .locked(lk0), .err_count(ec0));

    johnson_decoder #(.WIDTH(4), .LOCK_CNT(4), .ERRW(2)) dut1 (
        .clk(clk), .reset(rst1), .code_in(c1), .code_valid(v1),
        .index(idx1), .onehot(oh1), .code_ok(ok1), .seq_err(se1),
        .locked(lk1), .err_count(ec1));

    typedef struct packed {
        logic       sel;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       ok, se, lk;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   npass = 0, ntotal = 0, nvec = 0;

    task automatic vec(input bit s, input bit r, input bit v, input logic [3:0] c,
                       input int idx, input logic [7:0] oh, input bit ok,
                       input bit se, input bit lk, input int ec);
        exp_t x;
        @(negedge clk);
        if (!s) begin
            rst0 = r; v0 = v; c0 = c; rst1 = 1'b0; v1 = 1'b0;
        end else begin
            rst1 = r; v1 = v; c1 = c; rst0 = 1'b0; v0 = 1'b0;
        end
        x.sel = s; x.idx = 3'(idx); x.oh = oh; x.ok = ok;
        x.se = se; x.lk = lk; x.ec = 8'(ec);
        q.push_back(x);
    endtask

    // Monitor: every edge that follows an issued vector carries one response.
    always @(posedge clk) begin
        logic [22:0] act, want;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) act = {idx1, oh1, ok1, se1, lk1, 6'b0, ec1};
            else       act = {idx0, oh0, ok0, se0, lk0, ec0};
            want = {e.idx, e.oh, e.ok, e.se, e.lk, e.ec};
            ntotal++;
            if (act === want) npass++;
            else $display("FAIL vec%0d dut%0d: idx/oh/ok/se/lk/ec got %0d/%h/%b/%b/%b/%0d want %0d/%h/%b/%b/%b/%0d",
                          nvec, e.sel, act[22:20], act[19:12], act[11], act[10], act[9], act[7:0],
                          e.idx, e.oh, e.ok, e.se, e.lk, e.ec);
            nvec++;
        end
    end

    initial begin
        // reset and full cycle; lock on 5th sample
        vec(0,1,0,4'b0000, 0,8'h00,0,0,0,0);
        vec(0,0,1,4'b0000, 0,8'h01,1,0,0,0);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,0,0);
        vec(0,0,1,4'b1100, 2,8'h04,1,0,0,0);
        vec(0,0,1,4'b1110, 3,8'h08,1,0,0,0);
        vec(0,0,1,4'b1111, 4,8'h10,1,0,1,0);
        vec(0,0,1,4'b0111, 5,8'h20,1,0,1,0);
        vec(0,0,1,4'b0011, 6,8'h40,1,0,1,0);
        vec(0,0,1,4'b0001, 7,8'h80,1,0,1,0);
        vec(0,0,1,4'b0000, 0,8'h01,1,0,1,0);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,1,0);
        vec(0,0,1,4'b1100, 2,8'h04,1,0,1,0);
        vec(0,0,1,4'b1110, 3,8'h08,1,0,1,0);
        // illegal code while locked at 3
        vec(0,0,1,4'b0101, 3,8'h00,0,1,0,1);
        vec(0,0,0,4'b0000, 3,8'h00,0,0,0,1);
        // reacquire, then jump from 2 to 4 while locked
        vec(0,1,0,4'b0000, 0,8'h00,0,0,0,0);
        vec(0,0,1,4'b0000, 0,8'h01,1,0,0,0);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,0,0);
        vec(0,0,1,4'b1100, 2,8'h04,1,0,0,0);
        vec(0,0,1,4'b1110, 3,8'h08,1,0,0,0);
        vec(0,0,1,4'b1111, 4,8'h10,1,0,1,0);
        vec(0,0,1,4'b0111, 5,8'h20,1,0,1,0);
        vec(0,0,1,4'b0011, 6,8'h40,1,0,1,0);
        vec(0,0,1,4'b0001, 7,8'h80,1,0,1,0);
        vec(0,0,1,4'b0000, 0,8'h01,1,0,1,0);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,1,0);
        vec(0,0,1,4'b1100, 2,8'h04,1,0,1,0);
        vec(0,0,1,4'b1111, 4,8'h10,1,1,0,1);
        vec(0,0,1,4'b0111, 5,8'h20,1,0,0,1);
        vec(0,0,1,4'b0011, 6,8'h40,1,0,0,1);
        vec(0,0,1,4'b0001, 7,8'h80,1,0,0,1);
        vec(0,0,1,4'b0000, 0,8'h01,1,0,1,1);
        // wrap continues and stall on repeated code
        vec(0,0,1,4'b1000, 1,8'h02,1,0,1,1);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,1,1);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,1,1);
        vec(0,0,1,4'b1100, 2,8'h04,1,0,1,1);
        // gapped sampling, garbage on invalid cycles
        vec(0,1,0,4'b0000, 0,8'h00,0,0,0,0);
        vec(0,0,1,4'b0000, 0,8'h01,1,0,0,0);
        vec(0,0,0,4'b0101, 0,8'h01,1,0,0,0);
        vec(0,0,1,4'b1000, 1,8'h02,1,0,0,0);
        vec(0,0,0,4'b0101, 1,8'h02,1,0,0,0);
        vec(0,0,1,4'b1100, 2,8'h04,1,0,0,0);
        vec(0,0,0,4'b1010, 2,8'h04,1,0,0,0);
        vec(0,0,1,4'b1110, 3,8'h08,1,0,0,0);
        vec(0,0,0,4'b0000, 3,8'h08,1,0,0,0);
        vec(0,0,1,4'b1111, 4,8'h10,1,0,1,0);
        vec(0,0,0,4'b1000, 4,8'h10,1,0,1,0);
        vec(0,0,1,4'b0111, 5,8'h20,1,0,1,0);
        vec(0,0,0,4'b0101, 5,8'h20,1,0,1,0);
        vec(0,0,1,4'b1010, 5,8'h00,0,1,0,1);
        vec(0,0,0,4'b1010, 5,8'h00,0,0,0,1);
        // ERRW=2 saturation, then reset with code_valid high
        vec(1,1,0,4'b0000, 0,8'h00,0,0,0,0);
        vec(1,0,1,4'b0101, 0,8'h00,0,1,0,1);
        vec(1,0,1,4'b1010, 0,8'h00,0,1,0,2);
        vec(1,0,1,4'b0110, 0,8'h00,0,1,0,3);
        vec(1,0,1,4'b1001, 0,8'h00,0,1,0,3);
        vec(1,0,1,4'b1011, 0,8'h00,0,1,0,3);
        vec(1,0,1,4'b1100, 2,8'h04,1,0,0,3);
        vec(1,1,1,4'b1000, 0,8'h00,0,0,0,0);
        vec(1,0,1,4'b1000, 1,8'h02,1,0,0,0);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            ntotal++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
        end
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
